bcd_calc_engine: RTL and testbench

//  Multi-cycle BCD arithmetic core for the calculator. It replaces the parallel

---
 rtl/bcd_calc_engine.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_bcd_calc_engine.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bcd_calc_engine.sv
// ---------------------------------------------------------------------------
// bcd_calc_engine
//   Multi-cycle BCD arithmetic sequencer: add, sub, mul, div (quotient) on two
//   DIGITS-wide BCD operands.
//   Flow: capture -> BCD-to-binary (CONV) -> arithmetic (EXEC)
//         -> binary-to-BCD double-dabble (B2BCD) -> one-cycle DONE.
// Ports
//   clk        : system clock, rising edge
//   rstn       : asynchronous active-low reset
//   start      : operation request, sampled only in IDLE
//   op         : 00 add, 01 sub, 10 mul, 11 div
//   a_bcd      : operand A, BCD, MSD in top nibble
//   b_bcd      : operand B, BCD, MSD in top nibble
//   busy       : high while the operation is in flight
//   done       : one-cycle completion pulse
//   result_bcd : 2*DIGITS-digit BCD magnitude, held until next done
//   negative   : sub only, set when A < B
//   err        : 00 ok, 01 divide by zero, 10 invalid BCD digit
// ---------------------------------------------------------------------------
module bcd_calc_engine #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   result_bcd,
  output logic                  negative,
  output logic [1:0]            err
);

  localparam int BW = 4 * DIGITS;
  localparam int RW = 2 * BW;
  localparam int CW = $clog2(RW + 1);

  localparam logic [CW-1:0] CONV_LAST = CW'(DIGITS - 1);
  localparam logic [CW-1:0] EXEC_LAST = CW'(BW - 1);
  localparam logic [CW-1:0] DD_LAST   = CW'(RW - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DIV = 2'b01;
  localparam logic [1:0] ERR_BCD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_B2BCD = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // True when any nibble of the operand is outside 0..9.
  function automatic logic bad_bcd(input logic [BW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Double-dabble pre-shift correction: add 3 to every digit >= 5.
  function automatic logic [RW-1:0] dd_adjust(input logic [RW-1:0] v);
    logic [RW-1:0] r;
    r = v;
    for (int i = 0; i < 2*DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [1:0]      op_r, op_s;
  logic [BW-1:0]   a_sh_r, a_sh_s;      // captured BCD, shifted MSD-first
  logic [BW-1:0]   b_sh_r, b_sh_s;
  logic [RW-1:0]   a_bin_r, a_bin_s;    // A binary; multiplicand in mul
  logic [BW-1:0]   b_bin_r, b_bin_s;    // B binary; multiplier/divisor
  logic [RW-1:0]   res_r, res_s;        // product / quotient / dabble source
  logic [BW:0]     rem_r, rem_s;        // restoring-division remainder
  logic [RW-1:0]   bcd_r, bcd_s;        // double-dabble BCD accumulator
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            neg_r, neg_s;

  logic [RW-1:0]   result_s;
  logic            negative_s;
  logic [1:0]      err_s;
  logic            busy_s;
  logic            done_s;

  logic [3:0]      a_dig_s, b_dig_s;
  logic [BW-1:0]   a_conv_s, b_conv_s;
  logic [BW:0]     rem_shift_s;
  logic [BW:0]     rem_sub_s;
  logic [BW-1:0]   quot_shift_s;
  logic [RW-1:0]   dd_adj_s;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      op_r       <= 2'b00;
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      a_bin_r    <= '0;
      b_bin_r    <= '0;
      res_r      <= '0;
      rem_r      <= '0;
      bcd_r      <= '0;
      cnt_r      <= '0;
      neg_r      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_bcd <= '0;
      negative   <= 1'b0;
      err        <= 2'b00;
    end else begin
      state_r    <= state_s;
      op_r       <= op_s;
      a_sh_r     <= a_sh_s;
      b_sh_r     <= b_sh_s;
      a_bin_r    <= a_bin_s;
      b_bin_r    <= b_bin_s;
      res_r      <= res_s;
      rem_r      <= rem_s;
      bcd_r      <= bcd_s;
      cnt_r      <= cnt_s;
      neg_r      <= neg_s;
      busy       <= busy_s;
      done       <= done_s;
      result_bcd <= result_s;
      negative   <= negative_s;
      err        <= err_s;
    end
  end

  // Next-state and next-datapath logic for the sequencer.
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    a_sh_s     = a_sh_r;
    b_sh_s     = b_sh_r;
    a_bin_s    = a_bin_r;
    b_bin_s    = b_bin_r;
    res_s      = res_r;
    rem_s      = rem_r;
    bcd_s      = bcd_r;
    cnt_s      = cnt_r;
    neg_s      = neg_r;
    result_s   = result_bcd;
    negative_s = negative;
    err_s      = err;

    // Shared step values, one per phase.
    a_dig_s      = a_sh_r[BW-1 -: 4];
    b_dig_s      = b_sh_r[BW-1 -: 4];
    a_conv_s     = (a_bin_r[BW-1:0] * BW'(4'd10)) + BW'(a_dig_s);
    b_conv_s     = (b_bin_r * BW'(4'd10)) + BW'(b_dig_s);
    rem_shift_s  = {rem_r[BW-1:0], res_r[BW-1]};
    rem_sub_s    = rem_shift_s - {1'b0, b_bin_r};
    quot_shift_s = res_r[BW-1:0] << 1;
    dd_adj_s     = dd_adjust(bcd_r);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          op_s    = op;
          a_sh_s  = a_bcd;
          b_sh_s  = b_bcd;
          a_bin_s = '0;
          b_bin_s = '0;
          cnt_s   = '0;
          neg_s   = 1'b0;
          if (bad_bcd(a_bcd) || bad_bcd(b_bcd)) begin
            state_s    = ST_DONE;
            result_s   = '0;
            negative_s = 1'b0;
            err_s      = ERR_BCD;
          end else begin
            state_s = ST_CONV;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CONV: begin
        a_sh_s  = a_sh_r << 4;
        b_sh_s  = b_sh_r << 4;
        a_bin_s = {{BW{1'b0}}, a_conv_s};
        b_bin_s = b_conv_s;
        cnt_s   = cnt_r + CW'(1'b1);
        if (cnt_r == CONV_LAST) begin
          cnt_s = '0;
          rem_s = '0;
          // Quotient register starts as the dividend; product starts at zero.
          if (op_r == OP_DIV) begin
            res_s = {{BW{1'b0}}, a_conv_s};
          end else begin
            res_s = '0;
          end
          if ((op_r == OP_DIV) && (b_conv_s == '0)) begin
            state_s    = ST_DONE;
            result_s   = '0;
            negative_s = 1'b0;
            err_s      = ERR_DIV;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = ST_CONV;
        end
      end

      ST_EXEC: begin
        case (op_r)
          OP_ADD: begin
            res_s   = a_bin_r + {{BW{1'b0}}, b_bin_r};
            cnt_s   = '0;
            bcd_s   = '0;
            state_s = ST_B2BCD;
          end
          OP_SUB: begin
            if (a_bin_r[BW-1:0] < b_bin_r) begin
              res_s = {{BW{1'b0}}, b_bin_r - a_bin_r[BW-1:0]};
              neg_s = 1'b1;
            end else begin
              res_s = {{BW{1'b0}}, a_bin_r[BW-1:0] - b_bin_r};
              neg_s = 1'b0;
            end
            cnt_s   = '0;
            bcd_s   = '0;
            state_s = ST_B2BCD;
          end
          OP_MUL: begin
            if (b_bin_r[0]) begin
              res_s = res_r + a_bin_r;
            end else begin
              res_s = res_r;
            end
            a_bin_s = a_bin_r << 1;
            b_bin_s = b_bin_r >> 1;
            cnt_s   = cnt_r + CW'(1'b1);
            if (cnt_r == EXEC_LAST) begin
              cnt_s   = '0;
              bcd_s   = '0;
              state_s = ST_B2BCD;
            end else begin
              state_s = ST_EXEC;
            end
          end
          OP_DIV: begin
            // Restoring step: keep the trial subtraction only if no borrow.
            if (rem_shift_s >= {1'b0, b_bin_r}) begin
              rem_s = rem_sub_s;
              res_s = {{BW{1'b0}}, quot_shift_s | BW'(1'b1)};
            end else begin
              rem_s = rem_shift_s;
              res_s = {{BW{1'b0}}, quot_shift_s};
            end
            cnt_s = cnt_r + CW'(1'b1);
            if (cnt_r == EXEC_LAST) begin
              cnt_s   = '0;
              bcd_s   = '0;
              state_s = ST_B2BCD;
            end else begin
              state_s = ST_EXEC;
            end
          end
          default: begin
            state_s = ST_IDLE;
          end
        endcase
      end

      ST_B2BCD: begin
        bcd_s = {dd_adj_s[RW-2:0], res_r[RW-1]};
        res_s = res_r << 1;
        cnt_s = cnt_r + CW'(1'b1);
        if (cnt_r == DD_LAST) begin
          state_s    = ST_DONE;
          result_s   = {dd_adj_s[RW-2:0], res_r[RW-1]};
          negative_s = neg_r;
          err_s      = ERR_OK;
        end else begin
          state_s = ST_B2BCD;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    done_s = (state_s == ST_DONE);
    busy_s = (state_s == ST_CONV) || (state_s == ST_EXEC) || (state_s == ST_B2BCD);
  end

endmodule

// File: tb/tb_bcd_calc_engine.sv
module tb_bcd_calc_engine;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a_bcd;
  logic [7:0]  b_bcd;
  logic        busy;
  logic        done;
  logic [15:0] result_bcd;
  logic        negative;
  logic [1:0]  err;

  int n_vec;
  int n_miss;

  bcd_calc_engine #(.DIGITS(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .op         (op),
    .a_bcd      (a_bcd),
    .b_bcd      (b_bcd),
    .busy       (busy),
    .done       (done),
    .result_bcd (result_bcd),
    .negative   (negative),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency, handshake and outputs.
  // scramble: change inputs right after capture; pulse: poke start while busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] a,
                        input logic [7:0] b, input int lat, input logic [15:0] res,
                        input logic ng, input logic [1:0] e, input bit scramble,
                        input bit pulse);
    int  n;
    bit  seen;
    int  extra;
    @(negedge clk);
    op = o; a_bcd = a; b_bcd = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      op = 2'b10; a_bcd = 8'h99; b_bcd = 8'h77;
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, ".busy1"}, {31'd0, busy}, {31'd0, (lat > 1)});
      if (done) begin
        seen = 1'b1;
      end else if (pulse) begin
        start = (n == 4) || (n == 9) || (n == 15);
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".result"}, {16'd0, result_bcd}, {16'd0, res});
    chk({tag, ".neg"}, {31'd0, negative}, {31'd0, ng});
    chk({tag, ".err"}, {30'd0, err}, {30'd0, e});
    chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    if (pulse) begin
      extra = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({tag, ".extra_done"}, extra, 0);
    end
  endtask

  initial begin
    int dcount;
    n_vec = 0; n_miss = 0;
    rstn = 1'b0; start = 1'b0; op = 2'b00; a_bcd = 8'h00; b_bcd = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.result", {16'd0, result_bcd}, 32'd0);
    chk("rst.neg", {31'd0, negative}, 32'd0);
    chk("rst.err", {30'd0, err}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_op("add47_85", 2'b00, 8'h47, 8'h85, 20, 16'h0132, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op("sub12_57", 2'b01, 8'h12, 8'h57, 20, 16'h0045, 1'b1, 2'b00, 1'b0, 1'b0);
    run_op("sub33_33", 2'b01, 8'h33, 8'h33, 20, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op("sub90_05", 2'b01, 8'h90, 8'h05, 20, 16'h0085, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op("add99_99", 2'b00, 8'h99, 8'h99, 20, 16'h0198, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op("mul99_99", 2'b10, 8'h99, 8'h99, 27, 16'h9801, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op("mul00_57", 2'b10, 8'h00, 8'h57, 27, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op("div97_08", 2'b11, 8'h97, 8'h08, 27, 16'h0012, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op("div99_99", 2'b11, 8'h99, 8'h99, 27, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op("div50_00", 2'b11, 8'h50, 8'h00, 3, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b0);
    run_op("bad_a3A", 2'b00, 8'h3A, 8'h12, 1, 16'h0000, 1'b0, 2'b10, 1'b0, 1'b0);
    run_op("sub_neg", 2'b01, 8'h05, 8'h06, 20, 16'h0001, 1'b1, 2'b00, 1'b0, 1'b0);
    run_op("bad_b9F", 2'b01, 8'h12, 8'h9F, 1, 16'h0000, 1'b0, 2'b10, 1'b0, 1'b0);
    run_op("scramble", 2'b00, 8'h21, 8'h13, 20, 16'h0034, 1'b0, 2'b00, 1'b1, 1'b0);
    run_op("pulse_mul", 2'b10, 8'h25, 8'h04, 27, 16'h0100, 1'b0, 2'b00, 1'b0, 1'b1);
    run_op("mul12_34", 2'b10, 8'h12, 8'h34, 27, 16'h0408, 1'b0, 2'b00, 1'b0, 1'b0);

    // Abort a mul with reset at start+10.
    @(negedge clk);
    op = 2'b10; a_bcd = 8'h99; b_bcd = 8'h99; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort.result", {16'd0, result_bcd}, 32'd0);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.err", {30'd0, err}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 2) rstn = 1'b1;
      if (done) dcount++;
    end
    chk("abort.no_done", dcount, 0);
    run_op("post_rst", 2'b00, 8'h08, 8'h09, 20, 16'h0017, 1'b0, 2'b00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
